// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline buffer carrying PC + instruction with a valid/ready handshake.
// A 2-entry skid keeps the upstream ready fully registered. Also provides flush, NOP bubbles and perf counters.
module pipe_stage_buffer #(
    parameter int unsigned           PC_W      = 64,
    parameter int unsigned           INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(32'h00000013),
    parameter int unsigned           CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        // Stall accounting is independent of flush: a stalled flush cycle still counts.
        if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            if ((state_q != EMPTY) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = '0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (push) begin
                        state_d      = FULL;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Handshake outputs are registered copies of the next-state decode.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign out_instr = out_valid_q ? main_instr_q : NOP_INSTR;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
